// File: rtl/fu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fu_issue_ctrl
//  Description : Issue controller for a single functional unit. Buffers ops
//                in a 2-entry FIFO, launches one op at a time, waits a fixed
//                per-class latency, then captures the FU result into a
//                ready/valid output slot. Results are returned in issue order.
//  Revision    : 1.0 - initial release
// ============================================================================
module fu_issue_ctrl #(
    parameter int unsigned BASE_LAT = 1,
    parameter int unsigned MADD_LAT = 2
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    // upstream op handshake
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [5:0]  IN_INST,
    input  logic [31:0] IN_A,
    input  logic [31:0] IN_B,
    input  logic [31:0] IN_C,
    input  logic        IN_SELECT,
    // functional unit drive
    output logic [5:0]  FU_INST,
    output logic [31:0] FU_A,
    output logic [31:0] FU_B,
    output logic [31:0] FU_C,
    output logic        FU_SELECT,
    // functional unit results
    input  logic [31:0] FU_Z,
    input  logic [3:0]  FU_FLAGS,
    // downstream result handshake
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_Z,
    output logic [3:0]  OUT_FLAGS,
    output logic        BUSY
);

    // Latency counts truncated to the 3-bit counter (legal range 1..7)
    localparam logic [2:0] BASE_CNT = 3'(BASE_LAT);
    localparam logic [2:0] MADD_CNT = 3'(MADD_LAT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    // Packed op layout: {inst[102:97], a[96:65], b[64:33], c[32:1], sel[0]}
    logic [102:0] in_op;
    logic [102:0] head_op;
    logic [102:0] entry0_q, entry0_d;
    logic [102:0] entry1_q, entry1_d;
    logic [102:0] op_q, op_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    state_t       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_z_q, out_z_d;
    logic [3:0]   out_flags_q, out_flags_d;
    logic [5:0]   fu_inst_q;
    logic         push;
    logic         pop;
    logic         fifo_nonempty;
    logic         out_free;
    logic [2:0]   head_cnt;

    assign in_op         = {IN_INST, IN_A, IN_B, IN_C, IN_SELECT};
    assign head_op       = rd_ptr_q ? entry1_q : entry0_q;
    assign fifo_nonempty = (count_q != 2'd0);
    assign IN_READY      = (count_q != 2'd2);
    assign push          = IN_VALID & IN_READY;
    assign out_free      = ~out_valid_q | OUT_READY;
    assign head_cnt      = (head_op[102:100] == 3'b111) ? MADD_CNT : BASE_CNT;

    // Sequencer next-state: pop/launch, latency countdown, result capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        pop         = 1'b0;
        out_valid_d = out_valid_q & ~OUT_READY;
        out_z_d     = out_z_q;
        out_flags_d = out_flags_q;

        case (state_q)
            S_IDLE: begin
                if (fifo_nonempty) begin
                    pop = 1'b1;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q > 3'd1) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (out_free) begin
                    // Result is due and the output slot can take it
                    out_valid_d = 1'b1;
                    out_z_d     = FU_Z;
                    out_flags_d = FU_FLAGS;
                    if (fifo_nonempty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A pop always moves the head op into the operand registers
        if (pop) begin
            op_d    = head_op;
            cnt_d   = head_cnt;
            state_d = S_LAUNCH;
        end
    end

    // FIFO next-state: write at wr_ptr on push, advance rd_ptr on pop
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            if (wr_ptr_q) begin
                entry1_d = in_op;
            end else begin
                entry0_d = in_op;
            end
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Posedge state: FIFO, FSM, latency counter, operands, output slot
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            entry0_q    <= '0;
            entry1_q    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            out_z_q     <= 32'd0;
            out_flags_q <= 4'd0;
        end else begin
            entry0_q    <= entry0_d;
            entry1_q    <= entry1_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            out_z_q     <= out_z_d;
            out_flags_q <= out_flags_d;
        end
    end

    // FU opcode retimed to the falling edge so it only moves while CLOCK is low
    always_ff @(negedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            fu_inst_q <= 6'b000000;
        end else begin
            fu_inst_q <= op_q[102:97];
        end
    end

    assign FU_INST   = fu_inst_q;
    assign FU_A      = op_q[96:65];
    assign FU_B      = op_q[64:33];
    assign FU_C      = op_q[32:1];
    assign FU_SELECT = op_q[0];
    assign OUT_VALID = out_valid_q;
    assign OUT_Z     = out_z_q;
    assign OUT_FLAGS = out_flags_q;
    assign BUSY      = (state_q != S_IDLE) | fifo_nonempty;

endmodule
`default_nettype wire

// File: tb/tb_fu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fu_issue_ctrl
//  Description : Scoreboard bench for fu_issue_ctrl with a behavioural FU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fu_issue_ctrl;

    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [5:0]  IN_INST = 6'd0;
    logic [31:0] IN_A = 32'd0;
    logic [31:0] IN_B = 32'd0;
    logic [31:0] IN_C = 32'd0;
    logic        IN_SELECT = 1'b0;
    logic [5:0]  FU_INST;
    logic [31:0] FU_A;
    logic [31:0] FU_B;
    logic [31:0] FU_C;
    logic        FU_SELECT;
    logic [31:0] FU_Z;
    logic [3:0]  FU_FLAGS;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [31:0] OUT_Z;
    logic [3:0]  OUT_FLAGS;
    logic        BUSY;

    fu_issue_ctrl #(.BASE_LAT(1), .MADD_LAT(2)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INST(IN_INST),
        .IN_A(IN_A), .IN_B(IN_B), .IN_C(IN_C), .IN_SELECT(IN_SELECT),
        .FU_INST(FU_INST), .FU_A(FU_A), .FU_B(FU_B), .FU_C(FU_C),
        .FU_SELECT(FU_SELECT), .FU_Z(FU_Z), .FU_FLAGS(FU_FLAGS),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_Z(OUT_Z),
        .OUT_FLAGS(OUT_FLAGS), .BUSY(BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    // Behavioural functional unit: combinational on the issued operands
    always_comb begin
        FU_Z = FU_A ^ FU_B;
        if (FU_INST[5:3] == 3'b111) begin
            FU_Z = FU_A * FU_B + FU_C;
        end else begin
            case (FU_INST[2:0])
                3'b010:  FU_Z = FU_A + FU_B;
                3'b011:  FU_Z = FU_A - FU_B;
                3'b100:  FU_Z = FU_A << FU_B[4:0];
                3'b101:  FU_Z = FU_SELECT ? FU_A : FU_B;
                default: FU_Z = FU_A ^ FU_B;
            endcase
        end
        FU_FLAGS = {(FU_Z == 32'd0), FU_Z[31], FU_SELECT, FU_INST[0]};
    end

    typedef struct {
        logic [5:0]  inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        sel;
        logic [31:0] z;
        logic [3:0]  f;
    } vec_t;

    typedef struct {
        logic [31:0] z;
        logic [3:0]  f;
    } exp_t;

    vec_t vecs [8];
    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Advance to 1 time unit after the n-th next posedge
    task automatic step(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    // Drive one op until accepted; expected result enters the scoreboard at the handshake
    task automatic push_op(input int idx);
        int   t;
        exp_t e;
        bit   ok;
        IN_VALID  = 1'b1;
        IN_INST   = vecs[idx].inst;
        IN_A      = vecs[idx].a;
        IN_B      = vecs[idx].b;
        IN_C      = vecs[idx].c;
        IN_SELECT = vecs[idx].sel;
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 50) begin
            @(negedge CLOCK);
            if (IN_READY) ok = 1'b1;
            @(posedge CLOCK);
            t++;
        end
        if (ok) begin
            e.z = vecs[idx].z;
            e.f = vecs[idx].f;
            exp_q.push_back(e);
        end else begin
            check("push_timeout", 32'd0, 32'd1);
        end
        #1;
        IN_VALID = 1'b0;
    endtask

    // Monitor: a result is transferred on the posedge after a valid&ready negedge sample
    always @(negedge CLOCK) begin
        exp_t e;
        if (RESET_N && OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_z", OUT_Z, e.z);
                check("out_flags", 32'(OUT_FLAGS), 32'(e.f));
            end
        end
    end

    // FU_INST must hold through the high phase of every clock
    always @(posedge CLOCK) begin
        logic [5:0] v;
        if (RESET_N) begin
            v = FU_INST;
            #4;
            if (RESET_N) check("fu_inst_stable_clk_high", 32'(FU_INST), 32'(v));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  saw_valid;
        vecs[0] = '{6'b000010, 32'd5,       32'd7,       32'd0,  1'b0, 32'd12,        4'h0};
        vecs[1] = '{6'b111100, 32'd3,       32'd4,       32'd10, 1'b0, 32'd22,        4'h0};
        vecs[2] = '{6'b000011, 32'd5,       32'd7,       32'd0,  1'b0, 32'hFFFFFFFE,  4'h5};
        vecs[3] = '{6'b000100, 32'd1,       32'd31,      32'd0,  1'b0, 32'h80000000,  4'h4};
        vecs[4] = '{6'b000101, 32'h0000AAAA, 32'h00005555, 32'd0, 1'b1, 32'h0000AAAA, 4'h3};
        vecs[5] = '{6'b000101, 32'h0000AAAA, 32'h00005555, 32'd0, 1'b0, 32'h00005555, 4'h1};
        vecs[6] = '{6'b000000, 32'h00001234, 32'h00001234, 32'd0, 1'b0, 32'd0,        4'h8};
        vecs[7] = '{6'b111000, 32'h00010000, 32'h00010000, 32'd5, 1'b0, 32'd5,        4'h0};

        // Reset state
        #1;
        check("rst_in_ready", 32'(IN_READY), 32'd1);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_fu_inst", 32'(FU_INST), 32'd0);
        check("rst_out_z", OUT_Z, 32'd0);
        repeat (3) @(negedge CLOCK);
        RESET_N = 1'b1;
        step(1);

        // ADD: pushed at P0, popped P1, FU_INST at following negedge, result after P3
        push_op(0);
        check("add_fu_inst_before_pop", 32'(FU_INST), 32'd0);
        step(1);
        check("add_valid_p1", 32'(OUT_VALID), 32'd0);
        check("add_fu_inst_p1_high", 32'(FU_INST), 32'd0);
        check("add_fu_a", FU_A, 32'd5);
        check("add_fu_b", FU_B, 32'd7);
        @(negedge CLOCK); #1;
        check("add_fu_inst_negedge", 32'(FU_INST), 32'b000010);
        step(1);
        check("add_valid_p2", 32'(OUT_VALID), 32'd0);
        step(1);
        check("add_valid_p3", 32'(OUT_VALID), 32'd1);
        check("add_z_p3", OUT_Z, 32'd12);
        step(1);
        check("add_valid_cleared", 32'(OUT_VALID), 32'd0);
        check("add_busy_idle", 32'(BUSY), 32'd0);

        // MADD: result after P4
        push_op(1);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            check("madd_valid_early", 32'(OUT_VALID), 32'd0);
        end
        step(1);
        check("madd_valid_p4", 32'(OUT_VALID), 32'd1);
        check("madd_z_p4", OUT_Z, 32'd22);
        step(1);

        // Backpressure: four ops with OUT_READY low fill the FIFO and stall in WAIT
        OUT_READY = 1'b0;
        for (int i = 2; i < 6; i++) push_op(i);
        step(8);
        check("bp_in_ready_full", 32'(IN_READY), 32'd0);
        check("bp_out_valid", 32'(OUT_VALID), 32'd1);
        check("bp_out_z_first", OUT_Z, vecs[2].z);
        check("bp_busy", 32'(BUSY), 32'd1);
        check("bp_fu_a_held", FU_A, vecs[3].a);
        step(5);
        check("bp_fu_a_still_held", FU_A, vecs[3].a);
        check("bp_out_z_still", OUT_Z, vecs[2].z);
        OUT_READY = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            step(1);
            cyc++;
        end
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        step(3);
        check("bp_busy_after", 32'(BUSY), 32'd0);
        check("bp_valid_after", 32'(OUT_VALID), 32'd0);

        // Reset during WAIT of a MADD, with a second op buffered
        push_op(1);
        push_op(0);
        step(1);
        #2;
        RESET_N = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("mid_rst_out_z", OUT_Z, 32'd0);
        check("mid_rst_out_flags", 32'(OUT_FLAGS), 32'd0);
        check("mid_rst_fu_a", FU_A, 32'd0);
        check("mid_rst_fu_b", FU_B, 32'd0);
        check("mid_rst_fu_c", FU_C, 32'd0);
        check("mid_rst_fu_sel", 32'(FU_SELECT), 32'd0);
        check("mid_rst_fu_inst", 32'(FU_INST), 32'd0);
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        check("mid_rst_in_ready", 32'(IN_READY), 32'd1);
        // Handshake attempted while in reset must be discarded
        IN_VALID = 1'b1;
        IN_INST  = vecs[0].inst;
        IN_A     = vecs[0].a;
        IN_B     = vecs[0].b;
        step(2);
        IN_VALID = 1'b0;
        @(negedge CLOCK);
        RESET_N = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLOCK);
            if (OUT_VALID) saw_valid = 1'b1;
        end
        check("post_rst_no_valid", 32'(saw_valid), 32'd0);
        check("post_rst_busy", 32'(BUSY), 32'd0);
        step(1);

        // Op stream under irregular downstream backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) push_op(i);
                done = 1'b1;
            end
            begin
                int c2;
                c2 = 0;
                while ((!done || exp_q.size() != 0) && c2 < 600) begin
                    @(posedge CLOCK);
                    #1;
                    OUT_READY = ($urandom_range(0, 3) != 0);
                    c2++;
                end
                OUT_READY = 1'b1;
            end
        join
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        step(3);
        check("stream_busy_end", 32'(BUSY), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
